// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and defaults for the sprite frame scheduler
package sprite_pkg;

  localparam int COORD_W   = 11;
  localparam int COLOR_W   = 24;
  localparam int N_SPR_DEF = 4;
  localparam int SPR_W_DEF = 32;
  localparam int SPR_H_DEF = 32;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic               en;
  } sprite_t;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, combinational one-hot grant, registered pointer
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW:0]   idx;
  logic          found;

  // Scan from the pointer upward, wrapping once, and take the first requester.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        found               = 1'b1;
        grant[idx[PW-1:0]]  = 1'b1;
        ptr_nxt = (idx[PW-1:0] == PW'(N-1)) ? '0 : idx[PW-1:0] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr <= '0;
    else if (enable && found) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/sprite_frame_sched.sv
// rtl/sprite_frame_sched.sv - sprite update arbitration, vsync-atomic commit and pixel priority
module sprite_frame_sched
  import sprite_pkg::*;
#(
  parameter int                 N_SPR    = N_SPR_DEF,
  parameter int                 SPR_W    = SPR_W_DEF,
  parameter int                 SPR_H    = SPR_H_DEF,
  parameter int                 H_ACT    = 640,
  parameter int                 V_ACT    = 480,
  parameter logic [COLOR_W-1:0] BG_COLOR = 24'h000000
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic [N_SPR-1:0]           iReq,
  input  logic [N_SPR*COORD_W-1:0]   iReq_X,
  input  logic [N_SPR*COORD_W-1:0]   iReq_Y,
  input  logic [N_SPR*COLOR_W-1:0]   iReq_Color,
  input  logic [N_SPR-1:0]           iReq_En,
  output logic [N_SPR-1:0]           oAck,
  input  logic [COORD_W-1:0]         iCur_X,
  input  logic [COORD_W-1:0]         iCur_Y,
  input  logic                       iVGA_VS,
  output logic [7:0]                 oRed,
  output logic [7:0]                 oGreen,
  output logic [7:0]                 oBlue,
  output logic                       oFrame_Tick
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACT - SPR_W);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACT - SPR_H);

  typedef enum logic {ACCEPT, COMMIT} state_t;

  state_t             state;
  sprite_t            shadow [N_SPR];
  sprite_t            active [N_SPR];
  logic               vs_s1, vs_s2, vs_prev, vs_edge;
  logic               grant_en;
  logic [N_SPR-1:0]   grant;
  logic [N_SPR-1:0]   hit;
  logic [COLOR_W-1:0] rgb_nxt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vs_s1   <= 1'b1;
      vs_s2   <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_s1   <= iVGA_VS;
      vs_s2   <= vs_s1;
      vs_prev <= vs_s2;
    end
  end

  assign vs_edge  = vs_prev & ~vs_s2;
  assign grant_en = (state == ACCEPT) && !vs_edge;

  // Masking with oAck stops a requester being captured twice while it drops iReq.
  rr_arbiter #(.N(N_SPR)) u_arb (
    .clk    (iCLK),
    .rst_n  (iRST_N),
    .req    (iReq & ~oAck),
    .enable (grant_en),
    .grant  (grant)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= ACCEPT;
      oAck        <= '0;
      oFrame_Tick <= 1'b0;
      for (int k = 0; k < N_SPR; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      oAck        <= '0;
      oFrame_Tick <= 1'b0;
      case (state)
        ACCEPT: begin
          if (vs_edge) begin
            state       <= COMMIT;
            oFrame_Tick <= 1'b1;
            for (int k = 0; k < N_SPR; k++) active[k] <= shadow[k];
          end else begin
            oAck <= grant;
            for (int k = 0; k < N_SPR; k++) begin
              if (grant[k]) begin
                shadow[k] <= '{x:     clamp_coord(iReq_X[COORD_W*k +: COORD_W], X_MAX),
                               y:     clamp_coord(iReq_Y[COORD_W*k +: COORD_W], Y_MAX),
                               color: iReq_Color[COLOR_W*k +: COLOR_W],
                               en:    iReq_En[k]};
              end
            end
          end
        end
        COMMIT: state <= ACCEPT;
        default: state <= ACCEPT;
      endcase
    end
  end

  // 12-bit compares so x+SPR_W near the top of the coordinate range cannot wrap.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_SPR; k++) begin
      hit[k] = active[k].en
            && ({1'b0, iCur_X} >= {1'b0, active[k].x})
            && ({1'b0, iCur_X} <  {1'b0, active[k].x} + 12'(SPR_W))
            && ({1'b0, iCur_Y} >= {1'b0, active[k].y})
            && ({1'b0, iCur_Y} <  {1'b0, active[k].y} + 12'(SPR_H));
    end
    rgb_nxt = BG_COLOR;
    for (int k = N_SPR-1; k >= 0; k--) begin
      if (hit[k]) rgb_nxt = active[k].color;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) {oRed, oGreen, oBlue} <= BG_COLOR;
    else         {oRed, oGreen, oBlue} <= rgb_nxt;
  end

endmodule

// File: tb/tb_sprite_frame_sched.sv
// tb/tb_sprite_frame_sched.sv - directed scoreboard bench for sprite_frame_sched
module tb_sprite_frame_sched;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*11-1:0] req_x = '0;
  logic [N*11-1:0] req_y = '0;
  logic [N*24-1:0] req_c = '0;
  logic [N-1:0]    req_en = '0;
  logic [N-1:0]    ack;
  logic [10:0]     cur_x = '0;
  logic [10:0]     cur_y = '0;
  logic            vs = 1'b1;
  logic [7:0]      red, green, blue;
  logic            tick;

  int          checks = 0;
  int          errors = 0;
  int          ack_q[$];
  logic [23:0] pix_q[$];
  int          cyc;

  always #5 clk = ~clk;

  sprite_frame_sched dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iReq        (req),
    .iReq_X      (req_x),
    .iReq_Y      (req_y),
    .iReq_Color  (req_c),
    .iReq_En     (req_en),
    .oAck        (ack),
    .iCur_X      (cur_x),
    .iCur_Y      (cur_y),
    .iVGA_VS     (vs),
    .oRed        (red),
    .oGreen      (green),
    .oBlue       (blue),
    .oFrame_Tick (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [10:0] x, input logic [10:0] y,
                         input logic [23:0] c, input logic en);
    req_x[k*11 +: 11] = x;
    req_y[k*11 +: 11] = y;
    req_c[k*24 +: 24] = c;
    req_en[k]         = en;
    req[k]            = 1'b1;
  endtask

  task automatic wait_acks(input int bound, output int cycles);
    cycles = 0;
    while (ack_q.size() > 0 && cycles < bound) begin
      step();
      cycles++;
      chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if (ack_q.size() == 0) chk("ack_unexpected", i, 32'd99);
          else                   chk("ack_order", i, ack_q.pop_front());
          req[i] = 1'b0;
        end
      end
    end
    if (ack_q.size() > 0) begin
      chk("ack_timeout", ack_q.size(), 0);
      ack_q.delete();
    end
  endtask

  task automatic do_req(input int k, input logic [10:0] x, input logic [10:0] y,
                        input logic [23:0] c, input logic en);
    int n;
    set_req(k, x, y, c, en);
    ack_q.push_back(k);
    wait_acks(8, n);
  endtask

  task automatic pix(input logic [10:0] x, input logic [10:0] y, input logic [23:0] exp,
                     input string tag);
    cur_x = x;
    cur_y = y;
    pix_q.push_back(exp);
    step();
    chk(tag, {red, green, blue}, pix_q.pop_front());
  endtask

  task automatic vs_commit();
    int n = 0;
    vs = 1'b0;
    do begin
      step();
      n++;
    end while (!tick && n < 10);
    chk("tick_latency", n, 3);
    step();
    chk("tick_single", tick, 0);
    vs = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_tick", tick, 0);
    chk("rst_rgb", {red, green, blue}, 24'h000000);
    rst_n = 1'b1;
    step();

    // round-robin from pointer 0
    for (int k = 0; k < N; k++) begin
      set_req(k, 11'(k * 40), 11'd0, 24'h0, 1'b0);
      ack_q.push_back(k);
    end
    wait_acks(12, cyc);
    chk("rr_all_cycles", cyc, 4);
    set_req(1, 11'd0, 11'd0, 24'h0, 1'b0);
    set_req(3, 11'd0, 11'd0, 24'h0, 1'b0);
    ack_q.push_back(1);
    ack_q.push_back(3);
    wait_acks(8, cyc);
    chk("rr_pair_cycles", cyc, 2);

    // commit timing
    do_req(0, 11'd100, 11'd200, 24'hFF0000, 1'b1);
    pix(11'd110, 11'd210, 24'h000000, "pre_commit");
    vs_commit();
    pix(11'd110, 11'd210, 24'hFF0000, "post_commit");
    pix(11'd131, 11'd231, 24'hFF0000, "last_in_pixel");
    pix(11'd132, 11'd210, 24'h000000, "x_past_edge");
    pix(11'd110, 11'd232, 24'h000000, "y_past_edge");
    pix(11'd99,  11'd210, 24'h000000, "x_before_edge");

    // overlap priority
    do_req(1, 11'd290, 11'd290, 24'h00FF00, 1'b1);
    do_req(2, 11'd280, 11'd295, 24'h0000FF, 1'b1);
    vs_commit();
    pix(11'd300, 11'd300, 24'h00FF00, "overlap_low_wins");
    do_req(1, 11'd290, 11'd290, 24'h00FF00, 1'b0);
    pix(11'd300, 11'd300, 24'h00FF00, "disable_not_yet");
    vs_commit();
    pix(11'd300, 11'd300, 24'h0000FF, "overlap_disabled");

    // clamping
    do_req(3, 11'd630, 11'd470, 24'h123456, 1'b1);
    vs_commit();
    pix(11'd639, 11'd479, 24'h123456, "clamp_corner_hit");
    pix(11'd607, 11'd447, 24'h000000, "clamp_outside");
    pix(11'd608, 11'd448, 24'h123456, "clamp_origin_hit");

    // request rising together with the vsync edge
    req_x[2*11 +: 11] = 11'd0;
    req_y[2*11 +: 11] = 11'd0;
    req_c[2*24 +: 24] = 24'hABCDEF;
    req_en[2]         = 1'b1;
    vs = 1'b0;
    step();
    step();
    req[2] = 1'b1;
    step();
    chk("coll_tick", tick, 1);
    chk("coll_no_ack_edge", ack, 0);
    step();
    chk("coll_no_ack_commit", ack, 0);
    step();
    chk("coll_ack_after", ack, 4'b0100);
    req[2] = 1'b0;
    vs = 1'b1;
    repeat (3) step();
    pix(11'd5,   11'd5,   24'h000000, "coll_old_frame");
    pix(11'd300, 11'd300, 24'h0000FF, "coll_prev_value");
    vs_commit();
    pix(11'd5,   11'd5,   24'hABCDEF, "coll_next_frame");
    pix(11'd300, 11'd300, 24'h000000, "coll_moved");

    // asynchronous reset mid-frame
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", {red, green, blue}, 24'h000000);
    chk("async_rst_ack", ack, 0);
    chk("async_rst_tick", tick, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    pix(11'd5, 11'd5, 24'h000000, "rst_pre_commit");
    vs_commit();
    pix(11'd5,   11'd5,   24'h000000, "rst_cleared_0");
    pix(11'd110, 11'd210, 24'h000000, "rst_cleared_1");
    pix(11'd639, 11'd479, 24'h000000, "rst_cleared_2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
